// File: rtl/seg7_capture_decoder_if.sv
// ============================================================================
// Module      : seg7_capture_decoder_if
// Description : Segment-bus sample input and decoded-event valid/ready output
//               bundle for seg7_capture_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_capture_decoder_if;
    logic [0:6] display;
    logic       out_ready;
    logic       overrun_clr;
    logic       out_valid;
    logic [2:0] out_value;
    logic       out_dash;
    logic       out_invalid;
    logic       overrun;

    modport master (
        output display, out_ready, overrun_clr,
        input  out_valid, out_value, out_dash, out_invalid, overrun
    );

    modport slave (
        input  display, out_ready, overrun_clr,
        output out_valid, out_value, out_dash, out_invalid, overrun
    );
endinterface

`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
// ============================================================================
// Module      : seg7_capture_decoder
// Description : Debounces an active-low 7-segment bus, decodes each newly
//               stable pattern and offers it on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    seg7_capture_decoder_if.slave  bus
);

    localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);
    localparam logic [0:6] c_blank  = 7'b1111111;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    logic [0:6]  r_cand;
    logic [7:0]  r_cnt;
    logic [0:6]  r_last_acc;
    out_state_t  r_state;
    logic [2:0]  r_value;
    logic        r_dash;
    logic        r_invalid;
    logic        r_overrun;

    logic        w_match;
    logic        w_accept;
    logic        w_overwrite;
    logic [2:0]  w_dec_value;
    logic        w_dec_dash;
    logic        w_dec_invalid;

    // Decode the candidate, not the raw bus: cand equals display whenever
    // an accept can fire, and this keeps display off any long comb path.
    always_comb begin
        w_dec_value   = 3'd0;
        w_dec_dash    = 1'b0;
        w_dec_invalid = 1'b0;
        case (r_cand)
            7'b1000000: w_dec_value   = 3'd0;
            7'b1111001: w_dec_value   = 3'd1;
            7'b0100100: w_dec_value   = 3'd2;
            7'b0110000: w_dec_value   = 3'd3;
            7'b0011001: w_dec_value   = 3'd4;
            7'b0010010: w_dec_value   = 3'd5;
            7'b0000010: w_dec_value   = 3'd6;
            7'b0111111: w_dec_dash    = 1'b1;
            default:    w_dec_invalid = 1'b1;
        endcase
    end

    assign w_match     = (bus.display == r_cand);
    // Fires only on the edge that completes the run, so a held pattern
    // produces exactly one event and a return to last_acc produces none.
    assign w_accept    = w_match && (r_cnt == c_stable - 8'd1) && (r_cand != r_last_acc);
    assign w_overwrite = w_accept && (r_state == OUT_FULL) && !bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cand     <= c_blank;
            r_cnt      <= 8'd0;
            r_last_acc <= c_blank;
        end else begin
            if (!w_match) begin
                r_cand <= bus.display;
                r_cnt  <= 8'd1;
            end else if (r_cnt < c_stable) begin
                r_cnt  <= r_cnt + 8'd1;
            end
            if (w_accept) begin
                r_last_acc <= r_cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= OUT_EMPTY;
            r_value   <= 3'd0;
            r_dash    <= 1'b0;
            r_invalid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (w_accept) begin
                        r_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (!w_accept && bus.out_ready) begin
                        r_state <= OUT_EMPTY;
                    end
                end
                default: r_state <= OUT_EMPTY;
            endcase

            if (w_accept) begin
                r_value   <= w_dec_value;
                r_dash    <= w_dec_dash;
                r_invalid <= w_dec_invalid;
            end

            // A lost event must stay visible even if software clears at the same time.
            if (w_overwrite) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = (r_state == OUT_FULL);
    assign bus.out_value   = r_value;
    assign bus.out_dash    = r_dash;
    assign bus.out_invalid = r_invalid;
    assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire
